// File: rtl/fc_apb_master.sv
// fc_apb_master: APB initiator that runs one FC job per cmd_start.
//
// Job sequence: write CTRL=1, write CTRL=0, poll STATUS until bit0 is set
// (POLL_GAP idle cycles between polls), read CLK_COUNTER and MAX_INDEX, then
// pulse cmd_done. PSLVERR on any completing transfer aborts with cmd_error.
//
// Optional feature: define FC_APB_MST_TIMEOUT_EN to abort with cmd_error
// after TIMEOUT_LIMIT STATUS reads that did not report done.
//
// Ports:
//   CLK, RESETN        clock, asynchronous active-low reset
//   cmd_start          one-cycle job request (accepted only when idle)
//   cmd_busy           high while a job is in flight
//   cmd_done           one-cycle pulse, results valid
//   cmd_error          one-cycle pulse, job aborted
//   result_cycles      CLK_COUNTER value of the last successful job
//   result_index       MAX_INDEX value of the last successful job
//   PADDR..PSLVERR     APB initiator interface
module fc_apb_master #(
    parameter int unsigned POLL_GAP      = 4,
    parameter logic [31:0] TIMEOUT_LIMIT = 32'd1_000_000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        cmd_start,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        cmd_error,
    output logic [31:0] result_cycles,
    output logic [31:0] result_index,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [31:0] AddrCtrl   = 32'h0000_0000;
    localparam logic [31:0] AddrStatus = 32'h0000_0004;
    localparam logic [31:0] AddrCnt    = 32'h0000_0008;
    localparam logic [31:0] AddrIdx    = 32'h0000_000C;
    localparam logic [7:0]  GapLoad    = 8'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        StIdle, StWrSet, StWrClr, StRdStat, StGap, StRdCnt, StRdIdx, StFin, StErr
    } state_e;

    // Bus phase within a transfer state. PhIdle is the mandatory PSEL=0 cycle
    // between back-to-back transfers.
    typedef enum logic [1:0] {
        PhIdle, PhSetup, PhAccess
    } phase_e;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [7:0]  gap_q, gap_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] index_q, index_d;

    logic is_xfer;
    logic xfer_cmpl;
    logic poll_expired;

    assign is_xfer   = state_q inside {StWrSet, StWrClr, StRdStat, StRdCnt, StRdIdx};
    assign xfer_cmpl = is_xfer && (phase_q == PhAccess) && PREADY;

`ifdef FC_APB_MST_TIMEOUT_EN
    logic [31:0] poll_q, poll_d;

    always_comb begin
        poll_d = poll_q;
        if (state_q == StIdle && cmd_start) begin
            poll_d = '0;
        end else if (state_q == StRdStat && xfer_cmpl && !PSLVERR) begin
            poll_d = poll_q + 32'd1;
        end
    end

    // Evaluated for the read that is completing now, i.e. poll_q + 1 reads.
    assign poll_expired = (poll_q + 32'd1) >= TIMEOUT_LIMIT;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_d;
        end
    end
`else
    assign poll_expired = 1'b0;

    logic unused_timeout_limit;
    assign unused_timeout_limit = ^TIMEOUT_LIMIT;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        gap_d    = gap_q;
        cycles_d = cycles_q;
        index_d  = index_q;

        if (is_xfer) begin
            unique case (phase_q)
                PhIdle:  phase_d = PhSetup;
                PhSetup: phase_d = PhAccess;
                default: if (PREADY) phase_d = PhIdle;
            endcase
        end

        if (xfer_cmpl && PSLVERR) begin
            state_d = StErr;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_start) begin
                        state_d = StWrSet;
                        phase_d = PhSetup;
                    end
                end
                StWrSet:  if (xfer_cmpl) state_d = StWrClr;
                StWrClr:  if (xfer_cmpl) state_d = StRdStat;
                StRdStat: begin
                    if (xfer_cmpl) begin
                        if (PRDATA[0]) begin
                            state_d = StRdCnt;
                        end else if (poll_expired) begin
                            state_d = StErr;
                        end else if (POLL_GAP == 0) begin
                            state_d = StRdStat;
                        end else begin
                            state_d = StGap;
                            gap_d   = GapLoad;
                        end
                    end
                end
                StGap: begin
                    // The gap itself provides the idle bus cycles, so the
                    // next poll starts directly with SETUP.
                    if (gap_q == 8'd0) begin
                        state_d = StRdStat;
                        phase_d = PhSetup;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                StRdCnt: begin
                    if (xfer_cmpl) begin
                        cycles_d = PRDATA;
                        state_d  = StRdIdx;
                    end
                end
                StRdIdx: begin
                    if (xfer_cmpl) begin
                        index_d = PRDATA;
                        state_d = StFin;
                    end
                end
                StFin:   state_d = StIdle;
                StErr:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= StIdle;
            phase_q  <= PhIdle;
            gap_q    <= '0;
            cycles_q <= '0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            gap_q    <= gap_d;
            cycles_q <= cycles_d;
            index_q  <= index_d;
        end
    end

    // Address/direction/data depend only on the state, so they are stable
    // for the whole SETUP..ACCESS window by construction.
    always_comb begin
        PADDR  = 32'h0;
        PWRITE = 1'b0;
        PWDATA = 32'h0;
        case (state_q)
            StWrSet: begin
                PADDR  = AddrCtrl;
                PWRITE = 1'b1;
                PWDATA = 32'd1;
            end
            StWrClr: begin
                PADDR  = AddrCtrl;
                PWRITE = 1'b1;
            end
            StRdStat: PADDR = AddrStatus;
            StRdCnt:  PADDR = AddrCnt;
            StRdIdx:  PADDR = AddrIdx;
            default:  PADDR = 32'h0;
        endcase
    end

    assign PSEL          = is_xfer && (phase_q != PhIdle);
    assign PENABLE       = is_xfer && (phase_q == PhAccess);
    assign cmd_busy      = (state_q != StIdle);
    assign cmd_done      = (state_q == StFin);
    assign cmd_error     = (state_q == StErr);
    assign result_cycles = cycles_q;
    assign result_index  = index_q;

endmodule

// File: tb/tb_fc_apb_master.sv
// Directed self-checking bench for fc_apb_master with a small APB slave model.
module tb_fc_apb_master;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        cmd_start;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_error;
    logic [31:0] result_cycles;
    logic [31:0] result_index;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    always #5 CLK = ~CLK;

    fc_apb_master #(
        .POLL_GAP      (4),
        .TIMEOUT_LIMIT (32'd5)
    ) dut (
        .CLK           (CLK),
        .RESETN        (RESETN),
        .cmd_start     (cmd_start),
        .cmd_busy      (cmd_busy),
        .cmd_done      (cmd_done),
        .cmd_error     (cmd_error),
        .result_cycles (result_cycles),
        .result_index  (result_index),
        .PADDR         (PADDR),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR)
    );

    // Slave configuration, written only by the stimulus block.
    int          ws        = 0;
    int          done_on   = 3;   // STATUS read number that reports done, 0 = never
    int          stat_base = 0;
    bit          err_en    = 1'b0;
    logic [31:0] err_addr  = 32'h8;
    logic [31:0] cnt_val   = 32'h1234;
    logic [31:0] idx_val   = 32'h7;

    // Slave state.
    int wcnt       = 0;
    int stat_reads = 0;

    always_comb begin
        PRDATA  = 32'h0;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        if (PSEL && PENABLE) begin
            PREADY  = (wcnt >= ws);
            PSLVERR = err_en && PREADY && (PADDR == err_addr);
        end
        if (PSEL && !PWRITE) begin
            case (PADDR)
                32'h4:   PRDATA = {31'b0, (done_on != 0) && (stat_reads - stat_base + 1 >= done_on)};
                32'h8:   PRDATA = cnt_val;
                32'hC:   PRDATA = idx_val;
                default: PRDATA = 32'h0;
            endcase
        end
    end

    always @(posedge CLK) begin
        if (PSEL && PENABLE) begin
            if (PREADY) begin
                wcnt <= 0;
                if (PADDR == 32'h4 && !PWRITE) stat_reads <= stat_reads + 1;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // Bus monitor, sampled on the falling edge.
    logic [64:0] log_q[$];
    int          len_q[$];
    int          gap_q[$];
    logic [64:0] hold      = '0;
    logic [31:0] last_addr = 32'hFFFF_FFFF;
    bit          prev_cmpl = 1'b0;
    int          idle_run  = 0;
    int          acc_len   = 0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    int          stab_err  = 0;
    int          idle_err  = 0;
    int          rdw_err   = 0;

    always @(negedge CLK) begin
        if (cmd_done) done_cnt <= done_cnt + 1;
        if (cmd_error) err_cnt <= err_cnt + 1;
        prev_cmpl <= PSEL && PENABLE && PREADY;
        if (prev_cmpl && PSEL) idle_err <= idle_err + 1;
        if (PSEL && !PWRITE && PWDATA != 32'h0) rdw_err <= rdw_err + 1;
        if (!PSEL) begin
            idle_run <= idle_run + 1;
            acc_len  <= 0;
        end else if (!PENABLE) begin
            hold     <= {PWRITE, PADDR, PWDATA};
            idle_run <= 0;
            if (PADDR == 32'h4 && last_addr == 32'h4) gap_q.push_back(idle_run);
        end else begin
            if ({PWRITE, PADDR, PWDATA} != hold) stab_err <= stab_err + 1;
            if (PREADY) begin
                log_q.push_back({PWRITE, PADDR, PWDATA});
                len_q.push_back(acc_len + 1);
                acc_len   <= 0;
                last_addr <= PADDR;
            end else begin
                acc_len <= acc_len + 1;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] ent(input logic w, input logic [31:0] a, input logic [31:0] d);
        return {w, a, d};
    endfunction

    function automatic logic [64:0] get_log(input int i);
        if (i < log_q.size()) return log_q[i];
        return '1;
    endfunction

    function automatic int get_gap(input int i);
        if (i < gap_q.size()) return gap_q[i];
        return -1;
    endfunction

    function automatic int get_len(input int i);
        if (i < len_q.size()) return len_q[i];
        return -1;
    endfunction

    task automatic pulse_start();
        cmd_start = 1'b1;
        @(negedge CLK);
        cmd_start = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc, input string tag);
        int n = 0;
        while (!(cmd_done || cmd_error) && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_end_seen"}, 96'(cmd_done || cmd_error), 96'd1);
    endtask

    task automatic check_after_end(input string tag);
        @(negedge CLK);
        check({tag, "_done_low"}, 96'(cmd_done), 96'd0);
        check({tag, "_err_low"}, 96'(cmd_error), 96'd0);
        check({tag, "_busy_low"}, 96'(cmd_busy), 96'd0);
    endtask

    // Full successful job with POLL_GAP=4 and done on the 3rd STATUS read.
    task automatic check_std_log(input string t, input int lb, input int gb);
        check({t, "_nxfer"}, 96'(log_q.size() - lb), 96'd7);
        check({t, "_x0"}, 96'(get_log(lb + 0)), 96'(ent(1'b1, 32'h0, 32'h1)));
        check({t, "_x1"}, 96'(get_log(lb + 1)), 96'(ent(1'b1, 32'h0, 32'h0)));
        for (int i = 2; i < 5; i++) begin
            check({t, "_xstat"}, 96'(get_log(lb + i)), 96'(ent(1'b0, 32'h4, 32'h0)));
        end
        check({t, "_x5"}, 96'(get_log(lb + 5)), 96'(ent(1'b0, 32'h8, 32'h0)));
        check({t, "_x6"}, 96'(get_log(lb + 6)), 96'(ent(1'b0, 32'hC, 32'h0)));
        check({t, "_ngaps"}, 96'(gap_q.size() - gb), 96'd2);
        for (int i = 0; i < 2; i++) begin
            check({t, "_gap"}, 96'(get_gap(gb + i)), 96'd4);
        end
    endtask

    initial begin
        int lb;
        int gb;
        int nb;
        int d0;
        int e0;
        int n;

        RESETN    = 1'b0;
        cmd_start = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset state.
        check("rst_psel", 96'(PSEL), 96'd0);
        check("rst_penable", 96'(PENABLE), 96'd0);
        check("rst_pwrite", 96'(PWRITE), 96'd0);
        check("rst_paddr", 96'(PADDR), 96'd0);
        check("rst_pwdata", 96'(PWDATA), 96'd0);
        check("rst_busy", 96'(cmd_busy), 96'd0);
        check("rst_done", 96'(cmd_done), 96'd0);
        check("rst_err", 96'(cmd_error), 96'd0);
        check("rst_cycles", 96'(result_cycles), 96'd0);
        check("rst_index", 96'(result_index), 96'd0);
        RESETN = 1'b1;
        @(negedge CLK);

        // Basic job, zero wait states.
        lb = log_q.size(); gb = gap_q.size(); d0 = done_cnt; e0 = err_cnt;
        stat_base = stat_reads;
        pulse_start();
        check("t1_busy", 96'(cmd_busy), 96'd1);
        check("t1_setup_psel", 96'(PSEL), 96'd1);
        check("t1_setup_penable", 96'(PENABLE), 96'd0);
        check("t1_setup_pwrite", 96'(PWRITE), 96'd1);
        check("t1_setup_pwdata", 96'(PWDATA), 96'd1);
        wait_end(300, "t1");
        check("t1_done_pulse", 96'(cmd_done), 96'd1);
        check_after_end("t1");
        check_std_log("t1", lb, gb);
        check("t1_ndone", 96'(done_cnt - d0), 96'd1);
        check("t1_nerr", 96'(err_cnt - e0), 96'd0);
        check("t1_cycles", 96'(result_cycles), 96'h1234);
        check("t1_index", 96'(result_index), 96'd7);

        // Three wait states on every transfer.
        ws = 3;
        lb = log_q.size(); gb = gap_q.size(); nb = len_q.size(); d0 = done_cnt;
        stat_base = stat_reads;
        pulse_start();
        wait_end(400, "t2");
        check("t2_done_pulse", 96'(cmd_done), 96'd1);
        check_after_end("t2");
        check_std_log("t2", lb, gb);
        for (int i = 0; i < 7; i++) begin
            check("t2_access_len", 96'(get_len(nb + i)), 96'd4);
        end
        check("t2_ndone", 96'(done_cnt - d0), 96'd1);
        check("t2_cycles", 96'(result_cycles), 96'h1234);
        check("t2_index", 96'(result_index), 96'd7);

        // Slave error on the CLK_COUNTER read.
        ws = 0; err_en = 1'b1; err_addr = 32'h8; cnt_val = 32'hDEAD_BEEF;
        lb = log_q.size(); d0 = done_cnt; e0 = err_cnt;
        stat_base = stat_reads;
        pulse_start();
        wait_end(300, "t3");
        check("t3_err_pulse", 96'(cmd_error), 96'd1);
        check("t3_no_done", 96'(cmd_done), 96'd0);
        check_after_end("t3");
        check("t3_nxfer", 96'(log_q.size() - lb), 96'd6);
        check("t3_last", 96'(get_log(lb + 5)), 96'(ent(1'b0, 32'h8, 32'h0)));
        check("t3_ndone", 96'(done_cnt - d0), 96'd0);
        check("t3_nerr", 96'(err_cnt - e0), 96'd1);
        check("t3_cycles_kept", 96'(result_cycles), 96'h1234);
        check("t3_index_kept", 96'(result_index), 96'd7);
        err_en = 1'b0;

        // cmd_start pulsed while polling is ignored.
        cnt_val = 32'h00AB_CDEF; idx_val = 32'h55;
        lb = log_q.size(); gb = gap_q.size(); d0 = done_cnt;
        stat_base = stat_reads;
        pulse_start();
        n = 0;
        while (!(PSEL && PADDR == 32'h4) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("t4_poll_seen", 96'(PSEL && PADDR == 32'h4), 96'd1);
        pulse_start();
        wait_end(300, "t4");
        check_after_end("t4");
        check_std_log("t4", lb, gb);
        check("t4_ndone", 96'(done_cnt - d0), 96'd1);
        check("t4_cycles", 96'(result_cycles), 96'h00AB_CDEF);
        check("t4_index", 96'(result_index), 96'h55);

        // Reset during the ACCESS phase of a STATUS read.
        ws = 3; done_on = 0; cnt_val = 32'h1234; idx_val = 32'h7;
        d0 = done_cnt; e0 = err_cnt;
        stat_base = stat_reads;
        pulse_start();
        n = 0;
        while (!(PSEL && PENABLE && PADDR == 32'h4) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("t5_access_seen", 96'(PSEL && PENABLE && PADDR == 32'h4), 96'd1);
        RESETN = 1'b0;
        #1;
        check("t5_psel", 96'(PSEL), 96'd0);
        check("t5_penable", 96'(PENABLE), 96'd0);
        check("t5_paddr", 96'(PADDR), 96'd0);
        check("t5_pwdata", 96'(PWDATA), 96'd0);
        check("t5_busy", 96'(cmd_busy), 96'd0);
        check("t5_cycles", 96'(result_cycles), 96'd0);
        check("t5_index", 96'(result_index), 96'd0);
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        @(negedge CLK);
        check("t5_ndone", 96'(done_cnt - d0), 96'd0);
        check("t5_nerr", 96'(err_cnt - e0), 96'd0);
        ws = 0; done_on = 3;
        lb = log_q.size(); gb = gap_q.size(); d0 = done_cnt;
        stat_base = stat_reads;
        pulse_start();
        wait_end(300, "t5b");
        check("t5b_done_pulse", 96'(cmd_done), 96'd1);
        check_after_end("t5b");
        check_std_log("t5b", lb, gb);
        check("t5b_ndone", 96'(done_cnt - d0), 96'd1);
        check("t5b_cycles", 96'(result_cycles), 96'h1234);
        check("t5b_index", 96'(result_index), 96'd7);

`ifdef FC_APB_MST_TIMEOUT_EN
        // done never set: abort after TIMEOUT_LIMIT (5) STATUS reads.
        done_on = 0;
        lb = log_q.size(); d0 = done_cnt; e0 = err_cnt;
        stat_base = stat_reads;
        pulse_start();
        wait_end(400, "t6");
        check("t6_err_pulse", 96'(cmd_error), 96'd1);
        check_after_end("t6");
        n = 0;
        for (int i = lb; i < log_q.size(); i++) begin
            if (log_q[i][63:32] == 32'h4) n++;
        end
        check("t6_nstat", 96'(n), 96'd5);
        check("t6_nxfer", 96'(log_q.size() - lb), 96'd7);
        check("t6_ndone", 96'(done_cnt - d0), 96'd0);
        check("t6_nerr", 96'(err_cnt - e0), 96'd1);
`endif

        check("bus_stability", 96'(stab_err), 96'd0);
        check("bus_idle_between", 96'(idle_err), 96'd0);
        check("read_pwdata_zero", 96'(rdw_err), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_apb_master.md
FC_APB_MASTER -- requirements
Module: fc_apb_master

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4: idle cycles between consecutive STATUS reads (legal range 0..255).
REQ-002 SHALL have parameter TIMEOUT_LIMIT, default 32'd1_000_000: maximum STATUS reads before abort; used only when FC_APB_MST_TIMEOUT_EN is defined.
REQ-003 SHALL have port CLK  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RESETN  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_start  in  1  one-cycle request to run one FC job.
REQ-006 SHALL have port cmd_busy  out  1  high from cmd_start acceptance until cmd_done or cmd_error.
REQ-007 SHALL have port cmd_done  out  1  one-cycle pulse when results are valid.
REQ-008 SHALL have port cmd_error  out  1  one-cycle pulse on abort.
REQ-009 SHALL have port result_cycles  out  32  clk_counter value read from the FC block.
REQ-010 SHALL have port result_index  out  32  max_index value read from the FC block.
REQ-011 SHALL have APB initiator ports: PADDR out 32, PSEL out 1, PENABLE out 1, PWRITE out 1, PWDATA out 32, PRDATA in 32, PREADY in 1, PSLVERR in 1.

Function
REQ-012 SHALL use this register map: 0x00 CTRL (bit0 start), 0x04 STATUS (bit0 done), 0x08 CLK_COUNTER, 0x0C MAX_INDEX; PADDR[31:16] is always 0.
REQ-013 SHALL run FSM states IDLE, WR_SET, WR_CLR, RD_STAT, GAP, RD_CNT, RD_IDX, FIN, ERR.
REQ-014 SHALL accept cmd_start only in IDLE; cmd_start in any other state is ignored and has no side effect.
REQ-015 SHALL run the job sequence: WR_SET (write CTRL=1), WR_CLR (write CTRL=0), RD_STAT, then RD_CNT, RD_IDX, FIN, IDLE.
REQ-016 SHALL perform each APB transfer as a SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS cycles (PSEL=1, PENABLE=1) until PREADY=1.
REQ-017 SHALL hold PADDR, PWRITE and PWDATA stable from SETUP through the completing ACCESS cycle.
REQ-018 SHALL drive PSEL=0, PENABLE=0 for at least one cycle between transfers.
REQ-019 SHALL, when RD_STAT completes with PRDATA[0]=0, enter GAP for exactly POLL_GAP cycles and then re-enter RD_STAT; when POLL_GAP=0, SHALL go from RD_STAT directly back to RD_STAT.
REQ-020 SHALL, when RD_STAT completes with PRDATA[0]=1, proceed to RD_CNT.
REQ-021 SHALL capture PRDATA into result_cycles at RD_CNT completion and into result_index at RD_IDX completion.
REQ-022 SHALL hold result_cycles and result_index until the next capture.
REQ-023 SHALL pulse cmd_done for exactly one cycle in FIN, then return to IDLE.
REQ-024 SHALL, on PSLVERR=1 in any completing ACCESS cycle, go to ERR, pulse cmd_error for one cycle, leave the results unchanged, and return to IDLE.
REQ-025 SHALL keep cmd_busy=1 in every state except IDLE; cmd_busy is 0 in the cycle after FIN or ERR.
REQ-026 SHALL hold PWDATA at 0 during read transfers.

Reset
REQ-027 SHALL, asynchronously on RESETN=0, force state IDLE and set PSEL, PENABLE, PWRITE, cmd_busy, cmd_done and cmd_error to 0 and PADDR, PWDATA, result_cycles, result_index and the poll/gap counters to 0.
REQ-028 SHALL apply REQ-027 immediately when reset is asserted mid-transfer, abandoning the transfer with no cmd_done or cmd_error pulse.

Configuration
REQ-029 SHALL, with FC_APB_MST_TIMEOUT_EN defined, count completed STATUS reads and, when the count reaches TIMEOUT_LIMIT with done still 0, go to ERR (cmd_error pulse) instead of GAP; the counter clears on cmd_start acceptance.
REQ-030 SHALL, without FC_APB_MST_TIMEOUT_EN, poll indefinitely and contain no timeout counter logic.

Verification
REQ-031 SHALL cover this case: slave with PREADY=1 and done=1 on the 3rd STATUS read, CLK_COUNTER=0x1234, MAX_INDEX=7, POLL_GAP=4 -> transfers in the order W0x00=1, W0x00=0, R0x04 x3 each separated by a 4-cycle gap, R0x08, R0x0C; cmd_done pulses once; result_cycles=0x1234, result_index=7.
REQ-032 SHALL cover this case: slave inserts 3 wait states (PREADY=0) on every transfer -> PADDR, PWRITE and PWDATA stay stable and ACCESS lasts 4 cycles; final results identical to the previous case.
REQ-033 SHALL cover this case: PSLVERR=1 on the R0x08 transfer -> cmd_error pulses once, no cmd_done, result_cycles keeps its prior value, FSM returns to IDLE.
REQ-034 SHALL cover this case: cmd_start pulsed during polling -> no extra CTRL write occurs and exactly one cmd_done is produced.
REQ-035 SHALL cover this case: RESETN=0 during the ACCESS phase of R0x04 -> PSEL and PENABLE go to 0 in the same cycle, outputs take their reset values, and a new cmd_start after reset release runs a full sequence.
REQ-036 SHALL cover this case: with FC_APB_MST_TIMEOUT_EN defined, TIMEOUT_LIMIT=5 and done never set -> exactly 5 STATUS reads followed by a cmd_error pulse.
